// File: rtl/mux_rr_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// mux_rr_scheduler_pkg
// Shared constants, state encoding and the rotating-priority pick helper used
// by the round-robin mux scheduler and its picker sub-module.
// ---------------------------------------------------------------------------
package mux_rr_scheduler_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic             any;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First requester set when scanning ptr, ptr+1, ... (mod NREQ).
  // The scan runs from the farthest candidate down to ptr itself, so the
  // last overwrite is the one closest to ptr in rotation order.
  function automatic pick_t rr_pick(input logic [NREQ-1:0]  req,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res.any = 1'b0;
    res.idx = {SEL_W{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand    = ptr + SEL_W'(k);
      res.idx = req[cand] ? cand : res.idx;
      res.any = res.any | req[cand];
    end
    return res;
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// mux_rr_scheduler_if
// Bundle of the four requester lanes, the shared output stream and the
// grant/select observation outputs.
//   in_valid/in_data/in_last : requester beats (lane i = bits [i*WIDTH +: WIDTH])
//   in_ready                 : per-requester accept (one-hot or zero)
//   out_valid/out_data/out_last/out_ready : shared downstream stream
//   gnt/sel                  : registered grant and mux select
// modport slave  : the scheduler side
// modport master : the requesters + downstream side
// ---------------------------------------------------------------------------
interface mux_rr_scheduler_if #(
  parameter int WIDTH = 8
) ();
  import mux_rr_scheduler_pkg::*;

  logic [NREQ-1:0]       in_valid;
  logic [NREQ*WIDTH-1:0] in_data;
  logic [NREQ-1:0]       in_last;
  logic [NREQ-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic                  out_ready;
  logic [NREQ-1:0]       gnt;
  logic [SEL_W-1:0]      sel;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, gnt, sel
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, gnt, sel
  );

endinterface

// File: rtl/mux_rr_scheduler_rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational rotating-priority picker for four requesters.
//   req : request vector
//   ptr : index holding highest priority this round
//   idx : chosen requester (0 when nothing requested)
//   any : at least one request present
// ---------------------------------------------------------------------------
module rr_pick4
  import mux_rr_scheduler_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  pick_t pick_s;

  assign pick_s = rr_pick(req, ptr);
  assign idx    = pick_s.idx;
  assign any    = pick_s.any;

endmodule

// File: rtl/mux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mux_rr_scheduler
// Packet-level round-robin scheduler in front of a shared 4-to-1 mux.
// Grants one requester at a time, holds the grant until the packet's last
// beat is accepted (or MAX_BEATS beats have gone through) and routes that
// requester's beats onto the single output stream.
//   clk    : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : mux_rr_scheduler_if.slave (requester lanes, output stream,
//            gnt/sel observation)
// ---------------------------------------------------------------------------
module mux_rr_scheduler
  import mux_rr_scheduler_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                clk,
  input  logic                resetn,
  mux_rr_scheduler_if.slave   bus
);

  // A 1-bit counter is kept for MAX_BEATS == 1; it then sits at its limit.
  localparam int              CNT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  state_e           state_r,  state_nxt_s;
  logic [SEL_W-1:0] ptr_r,    ptr_nxt_s;
  logic [NREQ-1:0]  gnt_r,    gnt_nxt_s;
  logic [SEL_W-1:0] sel_r,    sel_nxt_s;
  logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;

  logic [SEL_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic             busy_s;
  logic             out_valid_s;
  logic             out_last_s;
  logic             xfer_s;
  logic [WIDTH-1:0] mux_data_s;

  rr_pick4 u_rr_pick4 (
    .req (bus.in_valid),
    .ptr (ptr_r),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // While busy, sel_r always equals the granted index, so it drives both the
  // lane mux and the per-lane valid/last lookups.
  assign busy_s      = (state_r == ST_BUSY);
  assign out_valid_s = busy_s & bus.in_valid[sel_r];
  assign out_last_s  = busy_s & (bus.in_last[sel_r] | (cnt_r == CNT_LAST));
  assign xfer_s      = out_valid_s & bus.out_ready;

  // Per-bit 4-to-1 mux, select bits s1 = sel_r[1], s0 = sel_r[0].
  for (genvar b = 0; b < WIDTH; b++) begin : g_bitmux
    assign mux_data_s[b] = sel_r[1]
      ? (sel_r[0] ? bus.in_data[3*WIDTH + b] : bus.in_data[2*WIDTH + b])
      : (sel_r[0] ? bus.in_data[1*WIDTH + b] : bus.in_data[b]);
  end

  assign bus.out_valid = out_valid_s;
  assign bus.out_last  = out_last_s;
  assign bus.out_data  = busy_s ? mux_data_s : {WIDTH{1'b0}};
  assign bus.in_ready  = gnt_r & {NREQ{busy_s & bus.out_ready}};
  assign bus.gnt       = gnt_r;
  assign bus.sel       = sel_r;

  // Next-state logic: arbitration in IDLE, beat counting and release in BUSY.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    gnt_nxt_s   = gnt_r;
    sel_nxt_s   = sel_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_nxt_s = ST_BUSY;
          gnt_nxt_s   = onehot(pick_idx_s);
          sel_nxt_s   = pick_idx_s;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (xfer_s && out_last_s) begin
          // Release; the requester after the current one leads next round.
          state_nxt_s = ST_IDLE;
          gnt_nxt_s   = {NREQ{1'b0}};
          ptr_nxt_s   = sel_r + SEL_W'(1);
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (xfer_s) begin
          // Cannot overflow: at CNT_LAST the beat is forced last.
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = {NREQ{1'b0}};
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, pointer, grant, select and beat counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      ptr_r   <= {SEL_W{1'b0}};
      gnt_r   <= {NREQ{1'b0}};
      sel_r   <= {SEL_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      gnt_r   <= gnt_nxt_s;
      sel_r   <= sel_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_scheduler
// Directed scenarios followed by randomized traffic, every cycle compared
// against a packet-level model of the scheduler (owner / beats / ptr).
// ---------------------------------------------------------------------------
module tb_mux_rr_scheduler;

  localparam int W  = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  mux_rr_scheduler_if #(.WIDTH(W)) bus ();

  mux_rr_scheduler #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: owner = -1 when no packet is granted.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;
  int m_sel   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] v);
    bus.in_data[i*W +: W] = v;
  endtask

  // Compare all outputs with the model, then advance the model over one edge.
  task automatic cycle();
    logic [3:0]   e_gnt, e_rdy, s_valid, s_last;
    logic         e_ov, e_ol, s_ordy;
    logic [W-1:0] e_data;
    bit           busy;
    #1;
    s_valid = bus.in_valid;
    s_last  = bus.in_last;
    s_ordy  = bus.out_ready;
    busy    = (m_owner >= 0);
    e_gnt   = 4'd0;
    e_ov    = 1'b0;
    e_ol    = 1'b0;
    e_data  = '0;
    if (busy) begin
      e_gnt  = 4'b0001 << m_owner;
      e_ov   = s_valid[m_owner];
      e_ol   = s_last[m_owner] || (m_beats == MB - 1);
      e_data = bus.in_data[m_owner*W +: W];
    end
    e_rdy = (busy && s_ordy) ? e_gnt : 4'd0;
    check_eq("gnt",       bus.gnt,       e_gnt);
    check_eq("sel",       bus.sel,       m_sel[1:0]);
    check_eq("out_valid", bus.out_valid, e_ov);
    check_eq("out_last",  bus.out_last,  e_ol);
    check_eq("in_ready",  bus.in_ready,  e_rdy);
    check_eq("out_data",  bus.out_data,  e_data);
    @(posedge clk);
    if (!resetn) begin
      m_owner = -1; m_beats = 0; m_ptr = 0; m_sel = 0;
    end else if (!busy) begin
      for (int k = 0; k < 4; k++) begin
        int r;
        r = (m_ptr + k) % 4;
        if (m_owner < 0 && s_valid[r]) begin
          m_owner = r; m_sel = r; m_beats = 0;
        end
      end
    end else if (e_ov && s_ordy) begin
      if (e_ol) begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1; m_beats = 0;
      end else begin
        m_beats++;
      end
    end
    @(negedge clk);
  endtask

  logic [3:0] rr_gnt_exp [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
  logic [1:0] rr_sel_exp [10] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

  initial begin
    resetn        = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_last   = 4'b0000;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held with all requesters valid.
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_gnt", bus.gnt, 4'h0);
      check_eq("rst_sel", bus.sel, 2'd0);
      #1;
      check_eq("rst_out_valid", bus.out_valid, 1'b0);
      check_eq("rst_in_ready",  bus.in_ready,  4'h0);
      cycle();
    end

    // Round robin with 1-beat packets.
    resetn        = 1'b1;
    bus.in_last   = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_lane(i, W'(8'h10 + i));
    for (int i = 0; i < 10; i++) begin
      check_eq("rr_gnt", bus.gnt, rr_gnt_exp[i]);
      check_eq("rr_sel", bus.sel, rr_sel_exp[i]);
      cycle();
    end
    bus.in_valid = 4'b0000;
    cycle();

    // Three-beat packet on req2.
    bus.in_valid = 4'b0100;
    bus.in_last  = 4'b0000;
    set_lane(2, 8'hA1);
    cycle();
    #1 check_eq("mb_a1", bus.out_data, 8'hA1);
    cycle();
    set_lane(2, 8'hA2);
    #1 check_eq("mb_a2", bus.out_data, 8'hA2);
    cycle();
    set_lane(2, 8'hA3);
    bus.in_last = 4'b0100;
    #1 check_eq("mb_a3", bus.out_data, 8'hA3);
    check_eq("mb_a3_last", bus.out_last, 1'b1);
    cycle();
    bus.in_valid = 4'b1111;
    bus.in_last  = 4'b1111;
    check_eq("mb_bubble", bus.gnt, 4'h0);
    cycle();
    check_eq("mb_ptr3", bus.gnt, 4'h8);
    cycle();
    bus.in_valid = 4'b0000;
    cycle();

    // Backpressure and a valid gap inside a req1 packet.
    bus.in_valid = 4'b0010;
    bus.in_last  = 4'b0000;
    set_lane(1, 8'h11);
    cycle();
    bus.in_valid = 4'b1111;
    #1 check_eq("bp_b1", bus.out_data, 8'h11);
    cycle();
    set_lane(1, 8'h12);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("bp_gnt_hold", bus.gnt, 4'h2);
      #1 check_eq("bp_in_ready", bus.in_ready, 4'h0);
      cycle();
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b1101;
    #1 check_eq("bp_gap_valid", bus.out_valid, 1'b0);
    cycle();
    bus.in_valid = 4'b1111;
    #1 check_eq("bp_b2", bus.out_data, 8'h12);
    cycle();
    set_lane(1, 8'h13);
    bus.in_last = 4'b0010;
    #1 check_eq("bp_b3_last", bus.out_last, 1'b1);
    cycle();
    bus.in_valid = 4'b0000;
    bus.in_last  = 4'b0000;
    cycle();

    // Beat limit on req3, then regrant only while nobody else is valid.
    bus.in_valid = 4'b1000;
    cycle();
    for (int b = 1; b <= 6; b++) begin
      set_lane(3, W'(8'h30 + b));
      bus.in_last = (b == 6) ? 4'b1000 : 4'b0000;
      #1 check_eq("bl_last", bus.out_last, (b == 4 || b == 6) ? 1'b1 : 1'b0);
      cycle();
      if (b == 4) begin
        check_eq("bl_release", bus.gnt, 4'h0);
        cycle();
        check_eq("bl_regrant", bus.gnt, 4'h8);
      end
    end
    bus.in_last = 4'b0000;
    cycle();
    for (int b = 1; b <= 4; b++) begin
      if (b == 4) bus.in_valid = 4'b1001;
      cycle();
    end
    cycle();
    check_eq("bl_other_wins", bus.gnt, 4'h1);

    // Reset in the middle of a req0 packet.
    bus.in_valid = 4'b0001;
    cycle();
    cycle();
    resetn = 1'b0;
    cycle();
    check_eq("mr_gnt", bus.gnt, 4'h0);
    #1 check_eq("mr_in_ready", bus.in_ready, 4'h0);
    cycle();
    resetn       = 1'b1;
    bus.in_valid = 4'b1111;
    cycle();
    check_eq("mr_ptr0", bus.gnt, 4'h1);
    cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      resetn        = ($urandom_range(0, 79) != 0);
      bus.in_valid  = 4'($urandom);
      bus.in_last   = 4'($urandom & $urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_data   = 32'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Packet-level round-robin scheduler that shares one 4-to-1 mux datapath among four requesters.
- Generates the 2-bit mux select (s1,s0) and a one-hot grant, and routes the granted requester's beats to a single valid/ready output.
- Holds the grant until the packet's last beat is accepted, or until the beat limit forces release.
- Sits in front of the shared mux datapath in the team's mux-primitive hierarchy.

Parameters:
WIDTH, 8, data width of each requester lane and of the output.
MAX_BEATS, 16, maximum beats per grant; on beat MAX_BEATS the block forces out_last and releases. Must be >= 1.

Ports:
clk  input  1  single clock; all state updates on rising edge.
resetn  input  1  synchronous, active-low reset; sampled on rising edge of clk.
in_valid  input  4  per-requester beat valid; bit i = requester i.
in_data  input  4*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
in_last  input  4  per-requester end-of-packet marker.
in_ready  output  4  one-hot or zero; in_ready[i] = gnt[i] & out_ready & busy.
out_valid  output  1  = busy & in_valid[g], where g is the granted index.
out_data  output  WIDTH  in_data lane g via the 4-to-1 mux; 0 when not busy.
out_last  output  1  = in_last[g] | (beat_cnt == MAX_BEATS-1), gated by busy.
out_ready  input  1  downstream accept.
gnt  output  4  registered one-hot grant; 0 in IDLE.
sel  output  2  registered mux select {s1,s0} = g; holds last value in IDLE.

Behaviour:
- Reset (resetn low at edge): state=IDLE, ptr=0, gnt=0, sel=0, beat_cnt=0. Combinationally out_valid=0, out_last=0, out_data=0, in_ready=0. Reset mid-packet abandons the packet with no further handshake.
- States: IDLE, BUSY. busy = (state==BUSY).
- IDLE:
  - If in_valid != 0, pick the first set bit scanning ptr, ptr+1, ... mod 4.
  - Next edge: gnt=onehot(pick), sel=pick, beat_cnt=0, state=BUSY.
  - No beat is accepted in IDLE, so there is a 1-cycle arbitration bubble. Minimum latency from in_valid rising to first possible transfer is 1 cycle.
- BUSY:
  - Transfer = out_valid & out_ready.
  - On transfer with out_last=0: beat_cnt++.
  - On transfer with out_last=1: state=IDLE, gnt=0, ptr=(g+1) mod 4, beat_cnt=0.
- Granted requester drops in_valid mid-packet: grant is held, out_valid=0, no timeout.
- Other requesters' in_valid changes while BUSY: ignored, no preemption.
- Packet of exactly one beat: in_last on the first beat releases after 1 transfer.
- Beat limit: beat_cnt is sized clog2(MAX_BEATS), range 0..MAX_BEATS-1, and never wraps. If MAX_BEATS=1, every beat is last.
- Back-to-back packets: after release, the next grant issues 1 cycle later (IDLE bubble). The same requester regains the grant only if no other requester is valid.
- Simultaneous requests in IDLE are resolved purely by ptr order.
- Invariants: gnt is never multi-hot. in_ready is asserted for at most one bit.

Decomposition:
- Shared package holds NREQ=4, SEL_W=2, state encoding (IDLE=1'b0, BUSY=1'b1) and a helper function for the rotate-priority pick.
- One sub-module, rr_pick4: combinational rotating-priority picker with inputs req[3:0] and ptr[1:0], outputs idx[1:0] and any. The top instantiates it plus the mux-select/grant registers and the beat counter.
- Data routing reuses the team's 4-to-1 mux per bit (generate over WIDTH), driven by sel.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with all in_valid=1111 -> gnt=0000, sel=00, out_valid=0, in_ready=0000. After release, first grant lands on req0 one cycle later.
- Round-robin fairness: all four continuously valid, 1-beat packets, out_ready=1 -> grant sequence 0,1,2,3,0 with one idle cycle between grants, and sel matching each grant.
- Multi-beat packet: req2 sends 3 beats 0xA1,0xA2,0xA3 (last on third) with out_ready=1 -> out_data sequence A1,A2,A3. Release after A3, ptr=3.
- Backpressure/stall: during a req1 packet, toggle out_ready low for 2 cycles and drop in_valid[1] for 1 cycle -> no beat lost or duplicated, grant held throughout, in_ready[1] low while out_ready low.
- Beat limit: MAX_BEATS=4, req3 streams 6 beats without in_last -> out_last forced on beat 4, release, and req3 granted again for beats 5-6 only if no other requester is valid.
- Reset mid-packet: assert resetn=0 after beat 2 of a req0 packet -> next cycle state IDLE, gnt=0, ptr=0, and no in_ready pulse during reset.
